uart_rx: RTL and testbench

UART receiver for the 8N1 serial link: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit. It sits at the FPGA serial input pin and delivers each received byte to fabric logic with a single-cycle valid strobe. It is the receive-side counterpart of the team's existing UART transmitter and shares its parameters and bit timing.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// the framing width, the receiver state encoding and the bit-timing helper.
package uart_pkg;

  // Payload width of one 8N1 character.
  localparam int DATA_W = 8;

  // Receiver control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Number of system clocks in one bit period.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for an asynchronous input. Every flop resets to 1 so
// an idle-high serial line never looks like a start bit while in reset.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("uart_rx_sync: STAGES must be at least 2");
    end
  endgenerate

  logic [STAGES-1:0] sync_p0;

  // Shift the raw input through the flop chain; the oldest bit is the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
    end else begin
      sync_p0 <= {sync_p0[STAGES-2:0], d};
    end
  end

  assign q = sync_p0[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Delivers each good byte with a one-cycle rx_valid strobe and flags a low
// stop bit with a one-cycle frame_err strobe.
//
// Optional build macro UART_RX_MAJORITY_EN: every sample point becomes a
// 2-of-3 vote over the synchronized line taken at mid-1, mid and mid+1. The
// decision is made at mid+1, so all sample points and strobes move one cycle
// later and a single-cycle glitch at a sample point is rejected. Without the
// macro a single sample is taken at mid-bit and no extra flops exist.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  generate
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
      $error("uart_rx: CLK_FREQ/BAUD must lie in 4..65535");
    end
  endgenerate

  // Count value at which a full bit period has elapsed since the last decision.
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  // Synchronized serial line; every decision below looks only at this.
  logic rx_s;

  uart_rx_sync #(
    .STAGES (2)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The start check decides one cycle after mid-bit so the vote can include
  // the sample after mid. Later bit periods are counted from that decision,
  // so they stay aligned to mid+1 without further adjustment.
  localparam logic [15:0] START_LAST = 16'(HALF_BIT);

  // 2-of-3 vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two previous line samples (mid-1 and mid when the decision is at mid+1).
  logic [1:0] hist_p1;

  // Keep the last two synchronized samples for the vote.
  always_ff @(posedge clk) begin
    hist_p1 <= {hist_p1[0], rx_s};
  end

  logic sample;
  assign sample = majority3(hist_p1[1], hist_p1[0], rx_s);
`else
  localparam logic [15:0] START_LAST = 16'(HALF_BIT - 1);

  logic sample;
  assign sample = rx_s;
`endif

  uart_state_e       state_q;
  uart_state_e       state_d;
  logic [15:0]       clk_count;
  logic [2:0]        bit_index;
  logic [DATA_W-1:0] shift;
  logic              tick;
  logic              valid_d;
  logic              err_d;

  // A sample point is reached when the bit-period counter hits its limit.
  always_comb begin
    tick = 1'b0;
    case (state_q)
      START:       tick = (clk_count == START_LAST);
      DATA, STOP:  tick = (clk_count == BIT_LAST);
      default:     tick = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: frame sequencing and false-start / break handling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (tick) state_d = sample ? IDLE : DATA;
      DATA:  if (tick && bit_index == 3'd7) state_d = STOP;
      // Leaving at mid-stop lets an immediately following start bit be caught.
      STOP:  if (tick) state_d = sample ? IDLE : BREAK;
      // A held-low line must go high before a new start can be detected.
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: strobe requests at the stop-bit sample and the busy flag.
  always_comb begin
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == STOP && tick) begin
      valid_d = sample;
      err_d   = ~sample;
    end
    rx_busy = (state_q != IDLE);
  end

  // Bit-period counter: held at zero while waiting, restarted at every decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_count <= '0;
    end else if (state_q == IDLE || state_q == BREAK || tick) begin
      clk_count <= '0;
    end else begin
      clk_count <= clk_count + 16'd1;
    end
  end

  // Data bit index: advances on each data sample, cleared outside DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_index <= '0;
    end else if (state_q != DATA) begin
      bit_index <= '0;
    end else if (tick) begin
      bit_index <= bit_index + 3'd1;
    end
  end

  // Shift register: LSB arrives first, so each new bit enters at the MSB.
  always_ff @(posedge clk) begin
    if (state_q == DATA && tick) begin
      shift <= {sample, shift[DATA_W-1:1]};
    end
  end

  // Registered outputs: byte capture and the two mutually exclusive strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= valid_d;
      frame_err <= err_d;
      if (valid_d) begin
        rx_data <= shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at 25 MHz / 115200 baud.
module tb_uart_rx;

  localparam int CLK_FREQ = 25_000_000;
  localparam int BAUD     = 115200;
  localparam int C        = CLK_FREQ / BAUD;
  localparam int HALF     = C / 2;
  localparam int LAT      = HALF + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #20 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every strobe seen on the falling edge.
  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  int          err_cnt  = 0;
  int          both_cnt = 0;
  int          long_cnt = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      got_t.push_back(cyc);
    end
    if (frame_err) err_cnt++;
    if (rx_valid && frame_err) both_cnt++;
    if (rx_valid && prev_valid) long_cnt++;
    prev_valid = rx_valid;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         rd = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Compare bytes received since the last call against the reference queue.
  task automatic verify(input string tag);
    chk({tag, "_count"}, got_q.size() - rd, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd + i < got_q.size())
        chk($sformatf("%s_byte%0d", tag, i), int'(got_q[rd + i]), int'(exp_q[i]));
    end
    rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  int          e0;
  int unsigned t0;
  int          fall_t;
  logic        busy_seen;
  logic        data_moved;
  logic [7:0]  rb;
  int          gap;
  logic [7:0]  gb;

  initial begin
    // Reset
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data",  int'(rx_data),   0);
    chk("rst_valid", int'(rx_valid),  0);
    chk("rst_ferr",  int'(frame_err), 0);
    chk("rst_busy",  int'(rx_busy),   0);
    rst = 1'b0;
    idle(C);

    // Single 0x55 with latency window
    e0 = err_cnt;
    t0 = cyc;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(2 * C);
    if (got_q.size() > rd)
      chk_rng("lat_55", int'(got_t[rd] - t0), LAT - 3, LAT + 3);
    else
      chk("lat_55_seen", 0, 1);
    verify("b55");
    chk("b55_ferr", err_cnt - e0, 0);

    // Back-to-back frames without idle gap
    e0 = err_cnt;
    exp_q.push_back(8'h00); send_frame(8'h00, 1'b1);
    exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'hA5); send_frame(8'hA5, 1'b1);
    idle(2 * C);
    verify("b2b");
    chk("b2b_ferr", err_cnt - e0, 0);

    // False start: 50 low cycles, then high
    e0 = err_cnt;
    t0 = cyc;
    busy_seen = 1'b0;
    fall_t = -1;
    rx_in = 1'b0;
    for (int i = 0; i < C; i++) begin
      if (i == 50) rx_in = 1'b1;
      @(negedge clk);
      if (!busy_seen && rx_busy) busy_seen = 1'b1;
      else if (busy_seen && !rx_busy && fall_t < 0) fall_t = int'(cyc - t0);
    end
    chk("fs_busy_rose", int'(busy_seen), 1);
    chk_rng("fs_busy_fall", fall_t, HALF, HALF + 5);
    verify("fs_none");
    chk("fs_ferr", err_cnt - e0, 0);
    idle(C);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(2 * C);
    verify("b3c");

    // Framing error followed by a held-low line
    e0 = err_cnt;
    send_frame(8'h81, 1'b0);
    data_moved = 1'b0;
    rx_in = 1'b0;
    for (int i = 0; i < 20 * C; i++) begin
      @(negedge clk);
      if (rx_data !== 8'h3C) data_moved = 1'b1;
    end
    chk("brk_data_held", int'(data_moved), 0);
    chk("brk_busy", int'(rx_busy), 1);
    chk("brk_ferr", err_cnt - e0, 1);
    idle(C);
    chk("brk_release_busy", int'(rx_busy), 0);
    verify("brk_none");
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(2 * C);
    verify("brk_a5");
    chk("brk_ferr_total", err_cnt - e0, 1);

    // Reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(rb_bit(8'h12, i));
    rst   = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_data",  int'(rx_data),   0);
    chk("mid_rst_valid", int'(rx_valid),  0);
    chk("mid_rst_ferr",  int'(frame_err), 0);
    chk("mid_rst_busy",  int'(rx_busy),   0);
    idle(10 * C);
    verify("mid_rst_none");
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1);
    idle(2 * C);
    verify("mid_rst_34");

    // One-cycle inverted glitch at every data mid-bit of 0x96
    e0 = err_cnt;
    gb = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx_in = gb[i];
      repeat (HALF) @(negedge clk);
      rx_in = ~gb[i];
      @(negedge clk);
      rx_in = gb[i];
      repeat (C - HALF - 1) @(negedge clk);
    end
    send_bit(1'b1);
    idle(2 * C);
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(gb);
`else
    exp_q.push_back(~gb);
`endif
    verify("glitch");
    chk("glitch_ferr", err_cnt - e0, 0);

    // Randomized bytes with random idle gaps
    e0 = err_cnt;
    for (int f = 0; f < 6; f++) begin
      rb  = 8'($urandom_range(0, 255));
      gap = int'($urandom_range(0, HALF));
      exp_q.push_back(rb);
      send_frame(rb, 1'b1);
      idle(gap);
    end
    idle(2 * C);
    verify("rand");
    chk("rand_ferr", err_cnt - e0, 0);

    chk("strobes_exclusive", both_cnt, 0);
    chk("valid_one_cycle", long_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
